// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - valid/ready operand and result bundle for alu_seq
// master drives operands and accepts results; slave is the execute unit.
interface alu_seq_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] src_b;
   logic [3:0]      op;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] alu_result;
   logic            zero;
   logic            negative;
   logic            carry;
   logic            overflow;
   logic            illegal;

   modport master (
      output in_valid, src_a, src_b, op, out_ready,
      input  in_ready, out_valid, alu_result, zero, negative, carry, overflow, illegal
   );

   modport slave (
      input  in_valid, src_a, src_b, op, out_ready,
      output in_ready, out_valid, alu_result, zero, negative, carry, overflow, illegal
   );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered valid/ready ALU with flags and optional shift-add multiplier
// Define ALU_SEQ_MUL_EN to implement MUL/MULHU; otherwise op codes 1010/1011 are illegal.
module alu_seq #(
   parameter int XLEN = 32
) (
   input logic       clk,
   input logic       rst_n,
   alu_seq_if.slave  bus
);
   localparam int SHAMT_W = $clog2(XLEN);

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_AND   = 4'b0010;
   localparam logic [3:0] OP_OR    = 4'b0011;
   localparam logic [3:0] OP_XOR   = 4'b0100;
   localparam logic [3:0] OP_SLT   = 4'b0101;
   localparam logic [3:0] OP_SLL   = 4'b0110;
   localparam logic [3:0] OP_SRL   = 4'b0111;
   localparam logic [3:0] OP_SLTU  = 4'b1000;
   localparam logic [3:0] OP_SRA   = 4'b1001;
`ifdef ALU_SEQ_MUL_EN
   localparam logic [3:0] OP_MUL   = 4'b1010;
   localparam logic [3:0] OP_MULHU = 4'b1011;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next_state;
   logic            w_in_ready;
   logic            w_out_valid;
   logic            w_accept;
   logic            w_consume;
   logic            w_is_mul;
   logic            w_mul_last;

   logic [XLEN-1:0] r_result;
   logic            r_zero;
   logic            r_neg;
   logic            r_carry;
   logic            r_ovf;
   logic            r_ill;

   logic [SHAMT_W-1:0] w_shamt;
   logic               w_is_sub;
   logic [XLEN-1:0]    w_b_eff;
   logic [XLEN:0]      w_sum;
   logic [XLEN-1:0]    w_alu_res;
   logic               w_alu_c;
   logic               w_alu_v;
   logic               w_alu_ill;

   assign w_accept  = bus.in_valid & w_in_ready;
   assign w_consume = w_out_valid & bus.out_ready;

   always_comb begin
      w_is_mul = 1'b0;
`ifdef ALU_SEQ_MUL_EN
      w_is_mul = (bus.op == OP_MUL) || (bus.op == OP_MULHU);
`endif
   end

   // Single-cycle datapath; SUB reuses the adder as A + ~B + 1.
   always_comb begin
      w_shamt   = bus.src_b[SHAMT_W-1:0];
      w_is_sub  = (bus.op == OP_SUB);
      w_b_eff   = w_is_sub ? ~bus.src_b : bus.src_b;
      w_sum     = {1'b0, bus.src_a} + {1'b0, w_b_eff} + {{XLEN{1'b0}}, w_is_sub};
      w_alu_res = '0;
      w_alu_c   = 1'b0;
      w_alu_v   = 1'b0;
      w_alu_ill = 1'b0;
      case (bus.op)
         OP_ADD, OP_SUB: begin
            w_alu_res = w_sum[XLEN-1:0];
            w_alu_c   = w_sum[XLEN];
            w_alu_v   = (bus.src_a[XLEN-1] == w_b_eff[XLEN-1]) &&
                        (w_sum[XLEN-1] != bus.src_a[XLEN-1]);
         end
         OP_AND:  w_alu_res = bus.src_a & bus.src_b;
         OP_OR:   w_alu_res = bus.src_a | bus.src_b;
         OP_XOR:  w_alu_res = bus.src_a ^ bus.src_b;
         OP_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
         OP_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, (bus.src_a < bus.src_b)};
         OP_SLL:  w_alu_res = bus.src_a << w_shamt;
         OP_SRL:  w_alu_res = bus.src_a >> w_shamt;
         OP_SRA:  w_alu_res = $unsigned($signed(bus.src_a) >>> w_shamt);
`ifdef ALU_SEQ_MUL_EN
         OP_MUL, OP_MULHU: begin
         end
`endif
         default: w_alu_ill = 1'b1;
      endcase
   end

`ifdef ALU_SEQ_MUL_EN
   logic [XLEN-1:0]    r_mcand;
   logic [2*XLEN-1:0]  r_acc;
   logic [SHAMT_W-1:0] r_cnt;
   logic               r_mulhu;
   logic [XLEN:0]      w_step_sum;
   logic [2*XLEN-1:0]  w_acc_next;
   logic [XLEN-1:0]    w_mul_res;

   // r_acc holds {partial product high half, remaining multiplier bits}.
   always_comb begin
      w_step_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
      w_acc_next = {w_step_sum, r_acc[XLEN-1:1]};
      w_mul_res  = r_mulhu ? w_acc_next[2*XLEN-1:XLEN] : w_acc_next[XLEN-1:0];
   end

   assign w_mul_last = (r_state == S_MUL) && (r_cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcand <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_mulhu <= 1'b0;
      end else if (w_accept && w_is_mul) begin
         r_mcand <= bus.src_a;
         r_acc   <= {{XLEN{1'b0}}, bus.src_b};
         r_cnt   <= SHAMT_W'(XLEN - 1);
         r_mulhu <= (bus.op == OP_MULHU);
      end else if (r_state == S_MUL) begin
         r_acc   <= w_acc_next;
         r_cnt   <= r_cnt - 1'b1;
      end
   end
`else
   assign w_mul_last = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next_state = w_is_mul ? S_MUL : S_DONE;
         S_MUL:  if (w_mul_last) w_next_state = S_DONE;
         S_DONE: begin
            if (w_accept)       w_next_state = w_is_mul ? S_MUL : S_DONE;
            else if (w_consume) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      w_out_valid = (r_state == S_DONE);
      w_in_ready  = rst_n && ((r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result <= '0;
         r_zero   <= 1'b0;
         r_neg    <= 1'b0;
         r_carry  <= 1'b0;
         r_ovf    <= 1'b0;
         r_ill    <= 1'b0;
      end else if (w_accept && !w_is_mul) begin
         r_result <= w_alu_res;
         r_zero   <= (w_alu_res == '0);
         r_neg    <= w_alu_res[XLEN-1];
         r_carry  <= w_alu_c;
         r_ovf    <= w_alu_v;
         r_ill    <= w_alu_ill;
      end
`ifdef ALU_SEQ_MUL_EN
      else if (w_mul_last) begin
         r_result <= w_mul_res;
         r_zero   <= (w_mul_res == '0);
         r_neg    <= w_mul_res[XLEN-1];
         r_carry  <= 1'b0;
         r_ovf    <= 1'b0;
         r_ill    <= 1'b0;
      end
`endif
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = w_out_valid;
   assign bus.alu_result = r_result;
   assign bus.zero       = r_zero;
   assign bus.negative   = r_neg;
   assign bus.carry      = r_carry;
   assign bus.overflow   = r_ovf;
   assign bus.illegal    = r_ill;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized bench for alu_seq against a behavioural queue model
// Honours ALU_SEQ_MUL_EN the same way as the design.
module tb_alu_seq;
   localparam int XLEN = 32;
   localparam int SHW  = $clog2(XLEN);
   localparam longint S_MAX = (longint'(1) << (XLEN - 1)) - 1;
   localparam longint S_MIN = -S_MAX - 1;
`ifdef ALU_SEQ_MUL_EN
   localparam int MUL_LAT = XLEN + 1;
`else
   localparam int MUL_LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_seq_if #(.XLEN(XLEN)) bus();
   alu_seq #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // fl = {zero, negative, carry, overflow, illegal}
   typedef struct {
      logic [XLEN-1:0] res;
      logic [4:0]      fl;
      int              due;
   } exp_t;
   exp_t q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic bit is_mul_op(input logic [3:0] op);
`ifdef ALU_SEQ_MUL_EN
      return (op == 4'd10) || (op == 4'd11);
`else
      return 1'b0;
`endif
   endfunction

   function automatic exp_t model(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      exp_t e;
      longint unsigned ua, ub, p;
      longint sa, sb, sv;
      int sh;
      logic c, v, ill;
      ua = a; ub = b;
      sa = $signed(a); sb = $signed(b);
      sh = int'(b[SHW-1:0]);
      e.res = '0; e.due = 0; c = 1'b0; v = 1'b0; ill = 1'b0; p = 0;
      case (op)
         4'd0: begin
            e.res = XLEN'(ua + ub);
            c = (ua + ub) > ((longint'(1) << XLEN) - 1);
            sv = sa + sb;
            v = (sv > S_MAX) || (sv < S_MIN);
         end
         4'd1: begin
            e.res = a - b;
            c = (ua >= ub);
            sv = sa - sb;
            v = (sv > S_MAX) || (sv < S_MIN);
         end
         4'd2: e.res = a & b;
         4'd3: e.res = a | b;
         4'd4: e.res = a ^ b;
         4'd5: e.res = {{(XLEN-1){1'b0}}, (sa < sb)};
         4'd6: e.res = a << sh;
         4'd7: e.res = a >> sh;
         4'd8: e.res = {{(XLEN-1){1'b0}}, (ua < ub)};
         4'd9: e.res = XLEN'(sa >>> sh);
`ifdef ALU_SEQ_MUL_EN
         4'd10: begin p = ua * ub; e.res = p[XLEN-1:0]; end
         4'd11: begin p = ua * ub; e.res = p[2*XLEN-1:XLEN]; end
`endif
         default: ill = 1'b1;
      endcase
      e.fl = {(e.res == '0), e.res[XLEN-1], c, v, ill};
      return e;
   endfunction

   // Per-cycle compare against the model; also advances the model on handshakes.
   always @(negedge clk) begin : cmp
      bit   ev, er;
      exp_t e;
      #2;
      if (!rst_n) begin
         chk("reset_outputs",
             {bus.out_valid, bus.in_ready, bus.alu_result,
              bus.zero, bus.negative, bus.carry, bus.overflow, bus.illegal}, 64'd0);
         q.delete();
      end else begin
         ev = (q.size() > 0) && (cyc >= q[0].due);
         chk("out_valid", bus.out_valid, ev);
         if (ev) begin
            chk("result", bus.alu_result, q[0].res);
            chk("flags", {bus.zero, bus.negative, bus.carry, bus.overflow, bus.illegal}, q[0].fl);
         end
         er = (q.size() == 0) || (ev && bus.out_ready);
         chk("in_ready", bus.in_ready, er);
         if (ev && bus.out_ready) void'(q.pop_front());
         if (bus.in_valid && er) begin
            e = model(bus.op, bus.src_a, bus.src_b);
            e.due = cyc + 1 + (is_mul_op(bus.op) ? XLEN : 0);
            q.push_back(e);
         end
      end
   end

   task automatic run_op(input string name, input logic [3:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp_res,
                         input logic [4:0] exp_fl, input int exp_lat);
      int n, lat;
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.op = op; bus.src_a = a; bus.src_b = b;
      #1;
      n = 0;
      while (!bus.in_ready && n < 100) begin @(negedge clk); #1; n++; end
      chk({name, "_accept"}, (n < 100), 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.src_a = $urandom; bus.src_b = $urandom;
      #1;
      lat = 1;
      while (!bus.out_valid && lat < 200) begin @(negedge clk); #1; lat++; end
      chk({name, "_latency"}, lat, exp_lat);
      chk({name, "_result"}, bus.alu_result, exp_res);
      chk({name, "_flags"}, {bus.zero, bus.negative, bus.carry, bus.overflow, bus.illegal}, exp_fl);
   endtask

   function automatic logic [XLEN-1:0] rnd_val();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return '1;
         2: return {1'b1, {(XLEN-1){1'b0}}};
         3: return {1'b0, {(XLEN-1){1'b1}}};
         4: return 1;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      exp_t e;
      bit [5:0] v;
      bit seen;
      int rst_hold;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.op = '0; bus.src_a = '0; bus.src_b = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Hand-computed values pinning the model.
      e = model(4'd0, 32'hFFFF_FFFF, 32'd1);
      chk("pin_add_res", e.res, 32'h0);              chk("pin_add_fl", e.fl, 5'b10100);
      e = model(4'd1, 32'h8000_0000, 32'd1);
      chk("pin_sub_res", e.res, 32'h7FFF_FFFF);      chk("pin_sub_fl", e.fl, 5'b00110);
      e = model(4'd5, 32'hFFFF_FFFF, 32'd1);         chk("pin_slt", e.res, 32'd1);
      e = model(4'd8, 32'hFFFF_FFFF, 32'd1);         chk("pin_sltu", e.res, 32'd0);
      e = model(4'd9, 32'h8000_0000, 32'h23);        chk("pin_sra", e.res, 32'hF000_0000);
      e = model(4'd7, 32'h8000_0000, 32'h23);        chk("pin_srl", e.res, 32'h1000_0000);
      e = model(4'd15, 32'h1234, 32'h5678);          chk("pin_ill_fl", e.fl, 5'b10001);

      run_op("add",  4'd0,  32'hFFFF_FFFF, 32'd1,  32'h0,         5'b10100, 1);
      run_op("sub",  4'd1,  32'h8000_0000, 32'd1,  32'h7FFF_FFFF, 5'b00110, 1);
      run_op("slt",  4'd5,  32'hFFFF_FFFF, 32'd1,  32'd1,         5'b00000, 1);
      run_op("sltu", 4'd8,  32'hFFFF_FFFF, 32'd1,  32'd0,         5'b10000, 1);
      run_op("sra",  4'd9,  32'h8000_0000, 32'h23, 32'hF000_0000, 5'b01000, 1);
      run_op("srl",  4'd7,  32'h8000_0000, 32'h23, 32'h1000_0000, 5'b00000, 1);
      run_op("ill",  4'd15, 32'hDEAD_BEEF, 32'h1,  32'h0,         5'b10001, 1);
`ifdef ALU_SEQ_MUL_EN
      run_op("mul",   4'd10, 32'h1_0000, 32'h1_0000, 32'h0, 5'b10000, MUL_LAT);
      run_op("mulhu", 4'd11, 32'h1_0000, 32'h1_0000, 32'h1, 5'b00000, MUL_LAT);
`else
      run_op("mul_ill", 4'd10, 32'h1_0000, 32'h1_0000, 32'h0, 5'b10001, MUL_LAT);
`endif

      // Three ops on consecutive cycles with the consumer always ready.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.out_ready = 1'b1;
         if (i < 3) begin
            bus.in_valid = 1'b1; bus.op = 4'd0; bus.src_a = i; bus.src_b = 32'd10;
         end else begin
            bus.in_valid = 1'b0;
         end
         #1;
         v[i] = bus.out_valid;
      end
      chk("b2b_pattern", v, 6'b001110);

      // Consumer stalls four cycles while another op waits.
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.op = 4'd4; bus.src_a = 32'hF0F0_F0F0; bus.src_b = 32'hFF00_FF00;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.op = 4'd0; bus.src_a = 32'd1; bus.src_b = 32'd1;
         #1;
         chk("hold_valid", bus.out_valid, 1);
         chk("hold_result", bus.alu_result, 32'h0FF0_0FF0);
         chk("hold_in_ready", bus.in_ready, 0);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1;
      chk("release_in_ready", bus.in_ready, 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      chk("release_next_valid", bus.out_valid, 1);
      chk("release_next_result", bus.alu_result, 32'd2);

      // Reset in the middle of a (possibly) long op aborts it.
      @(negedge clk);
      bus.in_valid = 1'b1; bus.op = 4'd10; bus.src_a = 32'h1234_5678; bus.src_b = 32'h9ABC_DEF0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", bus.out_valid, 0);
      chk("rst_mid_in_ready", bus.in_ready, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < XLEN + 5; i++) begin
         @(negedge clk);
         #1;
         seen |= bus.out_valid;
      end
      chk("rst_abort_no_valid", seen, 0);
      chk("rst_abort_result", bus.alu_result, 32'h0);

      // Random traffic; the compare process does the checking.
      rst_hold = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) rst_n = 1'b1;
         end else if ($urandom_range(0, 799) == 0) begin
            rst_n = 1'b0;
            rst_hold = $urandom_range(1, 3);
         end
         bus.in_valid  = ($urandom_range(0, 2) != 0);
         bus.op        = 4'($urandom_range(0, 15));
         bus.src_a     = rnd_val();
         bus.src_b     = rnd_val();
         bus.out_ready = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      repeat (XLEN + 5) @(negedge clk);
      #3;
      chk("drain_empty", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog");
   end
endmodule
